// File: rtl/complete_arb.sv
// Completion arbiter: grants up to CDB_WIDTH FU results per cycle onto a registered CDB (COMPLETE_RR_EN = rotating priority, else fixed).
// Latency: grant/fu_hazard same cycle, packet on cdb_* next cycle; losers see fu_hazard=1 and must hold req/packet.
package complete_arb_pkg;

  typedef struct packed {
    logic        valid;
    logic [5:0]  dest_prn;
    logic [31:0] dest_value;
    logic [4:0]  rob_idx;
    logic        take_branch;
    logic [31:0] target_pc;
  } fu_complete_packet_t;

endpackage

module complete_arb
  import complete_arb_pkg::*;
#(
  parameter int NUM_FU    = 8,
  parameter int CDB_WIDTH = 2,
  localparam int PW       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  squash,
  input  logic [NUM_FU-1:0]     fu_complete_req,
  input  fu_complete_packet_t   fu_out_pkt [NUM_FU],
  output logic [NUM_FU-1:0]     fu_hazard,
  output fu_complete_packet_t   cdb_pkt [CDB_WIDTH],
  output logic [CDB_WIDTH-1:0]  cdb_valid,
  output logic [PW-1:0]         rr_ptr
);

  localparam logic [PW:0] NUM_FU_W = (PW+1)'(NUM_FU);

  logic [NUM_FU-1:0]   grant;
  fu_complete_packet_t slot_pkt [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] slot_vld;
  logic [PW-1:0]       rr_ptr_q;
`ifdef COMPLETE_RR_EN
  logic [PW-1:0]       last_idx;
`endif

  // Walk the FUs in priority order from rr_ptr; the j-th winner lands in slot j.
  always_comb begin : grant_sel
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    int            cnt;
    grant    = '0;
    slot_vld = '0;
    for (int j = 0; j < CDB_WIDTH; j++) slot_pkt[j] = '0;
`ifdef COMPLETE_RR_EN
    last_idx = '0;
`endif
    sum = '0;
    idx = '0;
    cnt = 0;
    if (rst && !squash) begin
      for (int k = 0; k < NUM_FU; k++) begin
        sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (sum >= NUM_FU_W) sum = sum - NUM_FU_W;
        idx = sum[PW-1:0];
        if (fu_complete_req[idx] && cnt < CDB_WIDTH) begin
          grant[idx] = 1'b1;
          for (int j = 0; j < CDB_WIDTH; j++) begin
            if (cnt == j) begin
              slot_pkt[j]       = fu_out_pkt[idx];
              slot_pkt[j].valid = 1'b1;
              slot_vld[j]       = 1'b1;
            end
          end
`ifdef COMPLETE_RR_EN
          last_idx = idx;
`endif
          cnt = cnt + 1;
        end
      end
    end
  end

  // Reset and squash both suppress grants, so every requester is told to hold.
  assign fu_hazard = fu_complete_req & ~grant;

  // Squash needs no special case here: with no grants all slots load as empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid <= '0;
      for (int j = 0; j < CDB_WIDTH; j++) cdb_pkt[j] <= '0;
    end else begin
      cdb_valid <= slot_vld;
      for (int j = 0; j < CDB_WIDTH; j++) cdb_pkt[j] <= slot_pkt[j];
    end
  end

`ifdef COMPLETE_RR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else if (|grant) begin
      rr_ptr_q <= (last_idx == PW'(NUM_FU - 1)) ? '0 : last_idx + PW'(1);
    end
  end
`else
  assign rr_ptr_q = '0;
`endif

  assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_complete_arb.sv
// Directed bench for complete_arb with a queue-based reference model checked every cycle.
// Runs in both priority modes; expectations follow COMPLETE_RR_EN.
module tb_complete_arb;
  import complete_arb_pkg::*;

  localparam int NUM_FU    = 8;
  localparam int CDB_WIDTH = 2;
`ifdef COMPLETE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                squash;
  logic [NUM_FU-1:0]   fu_complete_req;
  fu_complete_packet_t fu_out_pkt [NUM_FU];
  logic [NUM_FU-1:0]   fu_hazard;
  fu_complete_packet_t cdb_pkt [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] cdb_valid;
  logic [2:0]          rr_ptr;

  complete_arb #(.NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH)) dut (
    .clk(clk), .rst(rst), .squash(squash),
    .fu_complete_req(fu_complete_req), .fu_out_pkt(fu_out_pkt),
    .fu_hazard(fu_hazard), .cdb_pkt(cdb_pkt), .cdb_valid(cdb_valid), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fu_complete_packet_t mkpkt(input int i, input logic [31:0] v);
    fu_complete_packet_t p;
    p             = '0;
    p.valid       = i[0];
    p.dest_prn    = 6'(i + 8);
    p.dest_value  = v;
    p.rob_idx     = 5'(i * 3);
    p.take_branch = i[1];
    p.target_pc   = 32'h1000 + 32'(i * 4);
    return p;
  endfunction

  // j-th requester found when listing requesters starting from ptr, or -1.
  function automatic int winner(input logic [NUM_FU-1:0] req, input int ptr, input int j);
    int q[$];
    for (int k = 0; k < NUM_FU; k++)
      if (req[(ptr + k) % NUM_FU]) q.push_back((ptr + k) % NUM_FU);
    return (j < q.size()) ? q[j] : -1;
  endfunction

  // Reference model state
  fu_complete_packet_t  m_pkt [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] m_vld;
  int                   m_ptr = 0;
  bit                   m_started = 1'b0;
  int                   m_w, m_last;

  always @(posedge clk) begin
    if (!rst || squash) begin
      m_vld = '0;
      for (int j = 0; j < CDB_WIDTH; j++) m_pkt[j] = '0;
      if (!rst) m_ptr = 0;
    end else begin
      m_last = -1;
      for (int j = 0; j < CDB_WIDTH; j++) begin
        m_w = winner(fu_complete_req, m_ptr, j);
        if (m_w >= 0) begin
          m_pkt[j]       = fu_out_pkt[m_w];
          m_pkt[j].valid = 1'b1;
          m_vld[j]       = 1'b1;
          m_last         = m_w;
        end else begin
          m_pkt[j] = '0;
          m_vld[j] = 1'b0;
        end
      end
      if (RR && m_last >= 0) m_ptr = (m_last + 1) % NUM_FU;
    end
    m_started = 1'b1;
  end

  logic [NUM_FU-1:0] c_grant;
  int                c_w;

  always @(negedge clk) begin
    if (m_started) begin
      c_grant = '0;
      if (rst && !squash) begin
        for (int j = 0; j < CDB_WIDTH; j++) begin
          c_w = winner(fu_complete_req, m_ptr, j);
          if (c_w >= 0) c_grant[c_w] = 1'b1;
        end
      end
      chk("model_hazard", 128'(fu_hazard), 128'(fu_complete_req & ~c_grant));
      chk("model_cdb_valid", 128'(cdb_valid), 128'(m_vld));
      for (int j = 0; j < CDB_WIDTH; j++)
        chk($sformatf("model_cdb_pkt%0d", j), 128'(cdb_pkt[j]), 128'(m_pkt[j]));
      chk("model_rr_ptr", 128'(rr_ptr), 128'(m_ptr));
    end
  end

  logic [7:0] f_haz [5];
  int         f_rr  [5];
  int         f_s0  [5];

  initial begin
    rst    = 1'b0;
    squash = 1'b0;
    fu_complete_req = 8'hFF;
    for (int i = 0; i < NUM_FU; i++) fu_out_pkt[i] = mkpkt(i, 32'(100 + i));

    // Reset with every FU requesting
    @(posedge clk);
    @(negedge clk);
    chk("rst_cdb_valid", 128'(cdb_valid), 128'(2'b00));
    chk("rst_rr_ptr", 128'(rr_ptr), 128'(0));
    chk("rst_hazard", 128'(fu_hazard), 128'(8'hFF));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_hazard", 128'(fu_hazard), 128'(8'hFC));
    @(posedge clk); #1 fu_complete_req = 8'h00;
    @(negedge clk);
    chk("rel_cdb_valid", 128'(cdb_valid), 128'(2'b11));
    chk("rel_slot0", 128'(cdb_pkt[0].dest_value), 128'(100));
    chk("rel_slot1", 128'(cdb_pkt[1].dest_value), 128'(101));
    chk("rel_rr_ptr", 128'(rr_ptr), 128'(RR ? 2 : 0));

    // Single request from FU 3
    @(posedge clk); #1;
    fu_out_pkt[3]   = mkpkt(3, 32'd35);
    fu_complete_req = 8'h08;
    @(negedge clk);
    chk("idle_cdb_valid", 128'(cdb_valid), 128'(2'b00));
    chk("sgl_hazard", 128'(fu_hazard), 128'(8'h00));
    @(posedge clk); #1 fu_complete_req = 8'h00;
    @(negedge clk);
    chk("sgl_cdb_valid", 128'(cdb_valid), 128'(2'b01));
    chk("sgl_slot0", 128'(cdb_pkt[0].dest_value), 128'(35));
    chk("sgl_rr_ptr", 128'(rr_ptr), 128'(RR ? 4 : 0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("sgl_drain_valid", 128'(cdb_valid), 128'(2'b00));

    // Contention among FUs 1,2,5 from rr_ptr 0
    @(posedge clk); #1;
    rst = 1'b0;
    fu_out_pkt[3] = mkpkt(3, 32'd103);
    @(posedge clk); #1;
    rst = 1'b1;
    fu_complete_req = 8'h26;
    @(negedge clk);
    chk("con_rr_start", 128'(rr_ptr), 128'(0));
    chk("con_hazard", 128'(fu_hazard), 128'(8'h20));
    @(posedge clk); #1 fu_complete_req = 8'h20;
    @(negedge clk);
    chk("con_cdb_valid", 128'(cdb_valid), 128'(2'b11));
    chk("con_slot0", 128'(cdb_pkt[0].dest_value), 128'(101));
    chk("con_slot1", 128'(cdb_pkt[1].dest_value), 128'(102));
    chk("con_rr_ptr", 128'(rr_ptr), 128'(RR ? 3 : 0));
    chk("con_hazard2", 128'(fu_hazard), 128'(8'h00));
    @(posedge clk); #1 fu_complete_req = 8'h00;
    @(negedge clk);
    chk("con5_cdb_valid", 128'(cdb_valid), 128'(2'b01));
    chk("con5_slot0", 128'(cdb_pkt[0].dest_value), 128'(105));
    chk("con5_rr_ptr", 128'(rr_ptr), 128'(RR ? 6 : 0));

    // All eight request continuously
    if (RR) begin
      f_haz = '{8'hFC, 8'hF3, 8'hCF, 8'h3F, 8'hFC};
      f_rr  = '{2, 4, 6, 0, 2};
      f_s0  = '{100, 102, 104, 106, 100};
    end else begin
      f_haz = '{8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC};
      f_rr  = '{0, 0, 0, 0, 0};
      f_s0  = '{100, 100, 100, 100, 100};
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    fu_complete_req = 8'hFF;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("fair_hazard%0d", c), 128'(fu_hazard), 128'(f_haz[c]));
      @(negedge clk);
      chk($sformatf("fair_valid%0d", c), 128'(cdb_valid), 128'(2'b11));
      chk($sformatf("fair_slot0_%0d", c), 128'(cdb_pkt[0].dest_value), 128'(f_s0[c]));
      chk($sformatf("fair_slot1_%0d", c), 128'(cdb_pkt[1].dest_value), 128'(f_s0[c] + 1));
      chk($sformatf("fair_rr%0d", c), 128'(rr_ptr), 128'(f_rr[c]));
    end

    // Squash with FUs 0,4 requesting; requests stay up afterwards
    #1;
    fu_complete_req = 8'h11;
    squash = 1'b1;
    #1 chk("sq_hazard", 128'(fu_hazard), 128'(8'h11));
    @(posedge clk); #1 squash = 1'b0;
    @(negedge clk);
    chk("sq_cdb_valid", 128'(cdb_valid), 128'(2'b00));
    chk("sq_rr_ptr", 128'(rr_ptr), 128'(RR ? 2 : 0));
    chk("sq_hazard2", 128'(fu_hazard), 128'(8'h00));
    @(posedge clk); #1 fu_complete_req = 8'h03;
    @(negedge clk);
    chk("postsq_valid", 128'(cdb_valid), 128'(2'b11));
    chk("postsq_slot0", 128'(cdb_pkt[0].dest_value), 128'(RR ? 104 : 100));
    chk("postsq_slot1", 128'(cdb_pkt[1].dest_value), 128'(RR ? 100 : 104));
    chk("postsq_rr_ptr", 128'(rr_ptr), 128'(RR ? 1 : 0));

    // Reset while the CDB holds results discards them
    @(posedge clk); #1;
    rst = 1'b0;
    fu_complete_req = 8'h00;
    @(negedge clk);
    chk("mr_pre_valid", 128'(cdb_valid), 128'(2'b11));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mr_cdb_valid", 128'(cdb_valid), 128'(2'b00));
    chk("mr_rr_ptr", 128'(rr_ptr), 128'(0));
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/complete_arb.md
# complete_arb

Completion-stage arbiter between the functional units (ALU, mult, load, branch) and the common data bus (CDB). Each cycle it collects FU completion requests, grants up to `CDB_WIDTH` of them, and registers the granted FU_COMPLETE_PACKETs onto the CDB for the ROB, RS wakeup and physical register file. Each losing FU receives a per-FU hazard (the FU's `bs_hazard`), which makes it hold its result and request. A rotating priority pointer keeps a continuously requesting FU from being starved.

## Interface
- `NUM_FU`, 8: number of FU completion ports.
- `CDB_WIDTH`, 2: CDB broadcast slots per cycle; 1 ≤ CDB_WIDTH ≤ NUM_FU.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset; **synchronous, active-low** (asserted when 0, sampled on `clk` rising edge).
- `squash` in 1: branch-mispredict flush; synchronous, active-high.
- `fu_complete_req` in NUM_FU: FU i has a finished result (e.g. `fum_complete_req`).
- `fu_out_pkt` in NUM_FU × FU_COMPLETE_PACKET: result packet of FU i.
- `fu_hazard` out NUM_FU: to FU i `bs_hazard`; 1 = not granted this cycle, hold.
- `cdb_pkt` out CDB_WIDTH × FU_COMPLETE_PACKET: registered broadcast packets.
- `cdb_valid` out CDB_WIDTH: slot k carries a valid packet.
- `rr_ptr` out $clog2(NUM_FU): current highest-priority FU index (debug/verification).

## Operation
- Grant selection (combinational):
  - Scan FUs starting at `rr_ptr`, wrapping modulo NUM_FU.
  - Grant the first CDB_WIDTH requesters found.
  - The j-th grant in scan order fills slot j.
- `fu_hazard[i] = fu_complete_req[i] & ~grant[i]`.
  - A non-requesting FU always sees 0.
  - `fu_hazard` is forced to all-1s for any FU with req=1 while `rst`=0 or `squash`=1.
- CDB register, on each clock edge:
  - Slot j ← the granted packet, `cdb_valid[j]` ← 1.
  - Unfilled slots ← packet all-zeros, `cdb_valid` 0.
  - Packet fields pass through unmodified, except that the packet `valid` field is written equal to `cdb_valid[j]`.
- Pointer update, when at least one grant is made: `rr_ptr` ← (index of the last granted FU + 1) mod NUM_FU.
- With no grant, `rr_ptr` holds.
- Squash:
  - The CDB register is cleared (all `cdb_valid` 0) on the next edge.
  - No grant is made that cycle.
  - `rr_ptr` holds.
  - FUs are flushed by their own squash logic; a request still high after the squash is arbitrated normally the following cycle.
- Reset: `cdb_valid`=0, `cdb_pkt`=0, `rr_ptr`=0. Reset has priority over squash.
- Reset mid-operation discards registered CDB contents without broadcast.

## Timing
- Request in cycle N, granted: `fu_hazard[i]`=0 in cycle N, and the packet is on `cdb_pkt`/`cdb_valid` in cycle N+1.
  - The FU may present a new result or drop its request in cycle N+1.
- Request in cycle N, not granted: `fu_hazard[i]`=1 in cycle N.
  - The FU must keep `fu_complete_req` and `fu_out_pkt` stable into N+1.
  - The arbiter does not latch losing packets.
- Maximum throughput: CDB_WIDTH packets per cycle. No combinational path from `fu_complete_req` to `cdb_*`.
- Boundary: with exactly CDB_WIDTH requesters, all are granted and none stall.
- Boundary: with zero requesters, all `cdb_valid` are 0 next cycle.
- Fairness bound: a continuously requesting FU is granted within ceil(NUM_FU/CDB_WIDTH) cycles.
- Pointer wrap: granting FU NUM_FU-1 last gives `rr_ptr`=0.

## Configuration
- Macro: `COMPLETE_RR_EN`.
  - Defined: rotating priority as above.
  - Undefined: fixed priority, lowest FU index first.
    - `rr_ptr` is tied to 0 and never updates.
    - No fairness bound applies.
    - Grant, hazard, CDB-register and squash rules are otherwise identical.

## Test plan
- Reset (`rst`=0 for 2 cycles) with all 8 FUs requesting:
  - During reset: `cdb_valid`=00, `rr_ptr`=0, `fu_hazard`=8'hFF.
  - First cycle after release: FUs 0,1 granted, and `cdb_valid`=11 with their packets on the following edge.
- Single request: FU 3 only, `dest_value`=35, for 1 cycle.
  - `fu_hazard[3]`=0.
  - Next cycle: `cdb_valid`=01 and slot 0 `dest_value`=35.
  - Cycle after: `cdb_valid`=00.
- Contention: FUs 1,2,5 request, rr_ptr=0.
  - Slots ← FU1, FU2; `fu_hazard`=8'h20; rr_ptr→3.
  - FU5 holds; granted next cycle in slot 0; rr_ptr→6.
- Fairness/wrap: all 8 request continuously.
  - Grant pairs {0,1},{2,3},{4,5},{6,7},{0,1}.
  - rr_ptr sequence 2,4,6,0,2.
- Squash: FUs 0,4 request while `squash`=1.
  - `fu_hazard`=8'h11.
  - Next cycle `cdb_valid`=00; rr_ptr unchanged.
- `COMPLETE_RR_EN` undefined: all 8 request for 3 cycles.
  - FUs 0,1 granted every cycle; FUs 2–7 hazard 1 throughout.
